// File: rtl/img_uart_streamer.sv
// img_uart_streamer: reads NUM_PIXELS greyscale bytes from a BRAM read port in
// address order and serializes them onto an 8N1 UART line, one byte per pixel.
// Optional feature macro: IMG_UART_STREAMER_CHECKSUM_EN appends one extra byte
// holding the mod-256 sum of the frame's pixels.
module img_uart_streamer #(
  parameter int CLOCKS_PER_BAUD = 50,
  parameter int NUM_PIXELS      = 16384,
  parameter int ADDR_WIDTH      = 14,
  parameter int READ_LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_in_n,
  input  logic                  start_in,
  input  logic [7:0]            pixel_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SEND, ST_DONE} state_t;

  localparam int BW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam int WW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [BW-1:0]         BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);
  localparam logic [WW-1:0]         WAIT_LAST = WW'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [3:0]            BIT_LAST  = 4'd9;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]         baud_cnt;
  logic [3:0]            bit_cnt;
  logic [WW-1:0]         wait_cnt;
  logic [7:0]            shreg;
  logic [9:0]            frame;
  logic                  fetch_last;
  logic                  byte_end;
  logic                  last_pix;
  logic                  final_byte;

`ifdef IMG_UART_STREAMER_CHECKSUM_EN
  logic                  ck_phase;
  logic [7:0]            csum;
`endif

  // Full 8N1 frame: stop bit, data MSB..LSB, start bit; indexed by bit_cnt.
  assign frame      = {1'b1, shreg, 1'b0};
  assign fetch_last = (wait_cnt == WAIT_LAST);
  assign byte_end   = (baud_cnt == BAUD_LAST) && (bit_cnt == BIT_LAST);
  assign last_pix   = (addr_q == LAST_ADDR);

`ifdef IMG_UART_STREAMER_CHECKSUM_EN
  // The checksum byte is the last one on the wire.
  assign final_byte = ck_phase;
`else
  assign final_byte = last_pix;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_in_n) state <= ST_IDLE;
    else           state <= state_nx;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nx = state;
    tx_out   = 1'b1;
    busy_out = 1'b0;
    done_out = 1'b0;
    addr_out = '0;
    case (state)
      ST_IDLE: begin
        if (start_in) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        busy_out = 1'b1;
        addr_out = addr_q;
        if (fetch_last) state_nx = ST_SEND;
      end
      ST_SEND: begin
        busy_out = 1'b1;
        addr_out = addr_q;
        tx_out   = frame[bit_cnt];
        if (byte_end) state_nx = final_byte ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done_out = 1'b1;
        state_nx = start_in ? ST_FETCH : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Address, BRAM wait, baud/bit counters and the latched byte.
  always_ff @(posedge clk) begin
    if (!rst_in_n) begin
      addr_q   <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      shreg    <= '0;
`ifdef IMG_UART_STREAMER_CHECKSUM_EN
      ck_phase <= 1'b0;
      csum     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          addr_q   <= '0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // Address 0 is already on the port in the start cycle, so the
          // first fetch of a frame is one cycle shorter than later ones.
          wait_cnt <= start_in ? WW'(1) : '0;
`ifdef IMG_UART_STREAMER_CHECKSUM_EN
          if (start_in) begin
            csum     <= '0;
            ck_phase <= 1'b0;
          end
`endif
        end
        ST_FETCH: begin
          if (fetch_last) begin
            wait_cnt <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
`ifdef IMG_UART_STREAMER_CHECKSUM_EN
            if (ck_phase) begin
              shreg <= csum;
            end else begin
              shreg <= pixel_in;
              csum  <= csum + pixel_in;
            end
`else
            shreg <= pixel_in;
`endif
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_SEND: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              // Address stops at the last pixel; it never wraps mid-frame.
              if (!last_pix) addr_q <= addr_q + ADDR_WIDTH'(1);
`ifdef IMG_UART_STREAMER_CHECKSUM_EN
              else ck_phase <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_uart_streamer.sv
// Directed bench for img_uart_streamer: CLOCKS_PER_BAUD=4, READ_LATENCY=2,
// NUM_PIXELS=4, BRAM holding {01,02,03,FF}. Outputs are traced per cycle and
// then compared against hand-computed vectors and byte decodes.
module tb_img_uart_streamer;
  localparam int CPB = 4;
  localparam int RL  = 2;
  localparam int NP  = 4;
  localparam int AW  = 14;
`ifdef IMG_UART_STREAMER_CHECKSUM_EN
  localparam int NB  = 5;
`else
  localparam int NB  = 4;
`endif
  localparam int GAP      = 10 * CPB + RL + 1;  // 43
  localparam int DONE_OFF = 3 + (NB - 1) * GAP + 10 * CPB;
  localparam int DEPTH    = 1024;
  localparam int T0       = 10;
  localparam int T1       = T0 + DONE_OFF;

  logic          clk = 1'b0;
  logic          rst_in_n;
  logic          start_in;
  logic [7:0]    pixel_in;
  logic [AW-1:0] addr_out;
  logic          tx_out, busy_out, done_out;

  img_uart_streamer #(
    .CLOCKS_PER_BAUD(CPB), .NUM_PIXELS(NP), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_in_n(rst_in_n), .start_in(start_in), .pixel_in(pixel_in),
    .addr_out(addr_out), .tx_out(tx_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  // BRAM model with a two-stage read pipeline.
  logic [7:0] mem [0:3];
  logic [7:0] p1, p2;
  initial begin
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'hFF;
    p1 = '0; p2 = '0;
  end
  always @(posedge clk) begin
    p1 <= mem[addr_out[1:0]];
    p2 <= p1;
  end
  assign pixel_in = p2;

  // Cycle counter and per-cycle trace sampled on the falling edge.
  int            cyc = 0;
  logic          tr_tx   [0:DEPTH-1];
  logic          tr_busy [0:DEPTH-1];
  logic          tr_done [0:DEPTH-1];
  logic [AW-1:0] tr_addr [0:DEPTH-1];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < DEPTH) begin
      tr_tx[cyc]   = tx_out;
      tr_busy[cyc] = busy_out;
      tr_done[cyc] = done_out;
      tr_addr[cyc] = addr_out;
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int   off;
    logic tx;
    logic busy;
    logic done;
    int   addr;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int s, nd, nb, b;
    logic [7:0] byte_exp [0:4];
    int         addr_exp [0:4];
    byte_exp[0] = 8'h01; byte_exp[1] = 8'h02; byte_exp[2] = 8'h03;
    byte_exp[3] = 8'hFF; byte_exp[4] = 8'h05;
    addr_exp[0] = 0; addr_exp[1] = 1; addr_exp[2] = 2; addr_exp[3] = 3; addr_exp[4] = 3;

    // {offset from T0, tx, busy, done, addr}
    tbl.push_back('{0,   1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1,   1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{2,   1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{3,   1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{6,   1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{7,   1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{10,  1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{11,  1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{38,  1'b0, 1'b1, 1'b0, 0});
    tbl.push_back('{39,  1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{42,  1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{43,  1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{45,  1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{46,  1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{89,  1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{131, 1'b1, 1'b1, 1'b0, 3});
    tbl.push_back('{132, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{136, 1'b1, 1'b1, 1'b0, 3});
    tbl.push_back('{171, 1'b1, 1'b1, 1'b0, 3});
`ifdef IMG_UART_STREAMER_CHECKSUM_EN
    tbl.push_back('{172, 1'b1, 1'b1, 1'b0, 3});
    tbl.push_back('{174, 1'b1, 1'b1, 1'b0, 3});
    tbl.push_back('{175, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{214, 1'b1, 1'b1, 1'b0, 3});
    tbl.push_back('{215, 1'b1, 1'b0, 1'b1, 0});
`else
    tbl.push_back('{172, 1'b1, 1'b0, 1'b1, 0});
`endif

    // Reset with start held high: reset must dominate.
    rst_in_n = 1'b0;
    start_in = 1'b1;
    to_cyc(3);
    rst_in_n = 1'b1;
    start_in = 1'b0;

    // Frame A, with an ignored re-pulse mid-frame.
    to_cyc(T0);       start_in = 1'b1;
    to_cyc(T0 + 1);   start_in = 1'b0;
    to_cyc(T0 + 50);  start_in = 1'b1;
    to_cyc(T0 + 51);  start_in = 1'b0;
    // Frame B starts from the DONE cycle, then is cut by reset.
    to_cyc(T1);       start_in = 1'b1;
    to_cyc(T1 + 1);   start_in = 1'b0;
    to_cyc(T1 + 60);  rst_in_n = 1'b0;
    to_cyc(T1 + 61);  rst_in_n = 1'b1;
    to_cyc(T1 + 262);

    // Reset state.
    chk("rst_tx",   32'(tr_tx[3]),   32'd1);
    chk("rst_busy", 32'(tr_busy[3]), 32'd0);
    chk("rst_done", 32'(tr_done[3]), 32'd0);
    chk("rst_addr", 32'(tr_addr[3]), 32'd0);
    chk("rst_busy_after", 32'(tr_busy[4]), 32'd0);

    // Vector table for frame A.
    foreach (tbl[i]) begin
      s = T0 + tbl[i].off;
      chk($sformatf("tx@%0d",   tbl[i].off), 32'(tr_tx[s]),   32'(tbl[i].tx));
      chk($sformatf("busy@%0d", tbl[i].off), 32'(tr_busy[s]), 32'(tbl[i].busy));
      chk($sformatf("done@%0d", tbl[i].off), 32'(tr_done[s]), 32'(tbl[i].done));
      chk($sformatf("addr@%0d", tbl[i].off), 32'(tr_addr[s]), 32'(tbl[i].addr));
    end

    // Byte decode: idle before start, start bit, data at mid-bit, stop bit.
    for (int k = 0; k < NB; k++) begin
      s = T0 + 3 + k * GAP;
      b = 0;
      for (int j = 0; j < 8; j++) b = b | (int'(tr_tx[s + CPB * (j + 1) + 2]) << j);
      chk($sformatf("idle_before_byte%0d", k), 32'(tr_tx[s - 1]), 32'd1);
      chk($sformatf("start_byte%0d", k), 32'(tr_tx[s + 2]), 32'd0);
      chk($sformatf("data_byte%0d", k), 32'(b), 32'(byte_exp[k]));
      chk($sformatf("stop_byte%0d", k), 32'(tr_tx[s + 9 * CPB + 2]), 32'd1);
      chk($sformatf("addr_byte%0d", k), 32'(tr_addr[s]), 32'(addr_exp[k]));
    end

    // Bit order of byte 0x01: every one of its 40 cycles.
    nd = 0;
    for (int c = 0; c < 10 * CPB; c++) begin
      b = ((c / CPB) == 1 || (c / CPB) == 9) ? 1 : 0;
      if (int'(tr_tx[T0 + 3 + c]) != b) nd++;
    end
    chk("bitorder_01_bad_cycles", 32'(nd), 32'd0);

    // Busy for the whole frame, done only once at the end.
    nd = 0; nb = 0;
    for (int c = 1; c < DONE_OFF; c++) begin
      if (tr_done[T0 + c] !== 1'b0) nd++;
      if (tr_busy[T0 + c] !== 1'b1) nb++;
    end
    chk("frameA_early_done", 32'(nd), 32'd0);
    chk("frameA_busy_gaps",  32'(nb), 32'd0);

    // Frame B from a start in the DONE cycle.
    chk("B_done_cycle", 32'(tr_done[T1]), 32'd1);
    chk("B_busy_T+1",   32'(tr_busy[T1 + 1]), 32'd1);
    chk("B_tx_T+2",     32'(tr_tx[T1 + 2]), 32'd1);
    chk("B_tx_T+3",     32'(tr_tx[T1 + 3]), 32'd0);
    chk("B_busy_T+60",  32'(tr_busy[T1 + 60]), 32'd1);

    // Mid-frame reset.
    chk("midrst_tx",   32'(tr_tx[T1 + 61]),   32'd1);
    chk("midrst_busy", 32'(tr_busy[T1 + 61]), 32'd0);
    chk("midrst_addr", 32'(tr_addr[T1 + 61]), 32'd0);
    nd = 0; nb = 0;
    for (int c = T1 + 61; c < T1 + 261; c++) begin
      if (tr_done[c] !== 1'b0) nd++;
      if (tr_busy[c] !== 1'b0) nb++;
      if (tr_tx[c] !== 1'b1) nb++;
    end
    chk("midrst_no_done", 32'(nd), 32'd0);
    chk("midrst_quiet",   32'(nb), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
